bf_block_serializer: RTL and testbench
======================================

# bf_block_serializer

Output stage of the Blowfish datapath and the read-out counterpart of the parallel block registers. It accepts one 64-bit cipher block per valid/ready handshake and streams it out one byte per cycle, most-significant byte first, on a second valid/ready interface. The serializer sits between the final round/output register and the byte-wide host or link interface, and it sustains back-to-back blocks with no bubble cycles.

## Interface
- BLOCK_W, 64, block width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, output beat width in bits.
- NBEATS, BLOCK_W/BYTE_W, derived; beats per block (8).
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous abort; discards the block currently held.
- in_data  in  BLOCK_W  block to serialize; bits [63:56] are sent first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the block can be accepted this cycle.
- out_data  out  BYTE_W  current byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the current byte.
- out_last  out  1  the current byte is the final byte of its block.
- busy  out  1  a block is held (state SHIFT).

## Operation
- States:
  - IDLE: no block held.
  - SHIFT: a block is held in the shift register and beat counter `cnt` (0..NBEATS-1) tracks the byte being sent.
- Input handshake: fires when `in_valid && in_ready`.
  - Loads in_data into the shift register, sets cnt=0, and moves to SHIFT.
- `in_ready = rst_released && !flush && (state==IDLE || (out_valid && out_ready && out_last))`.
  - in_ready is combinational from the state and out_ready.
  - in_ready does not depend on in_valid.
- Output:
  - `out_data` = upper BYTE_W bits of the shift register.
  - `out_valid` = (state==SHIFT).
  - `out_last` = (state==SHIFT && cnt==NBEATS-1).
- Output handshake: fires when `out_valid && out_ready`.
  - Not last byte: shift left by BYTE_W with zero fill, and cnt+1.
  - Last byte with input handshake in the same cycle: load the new block, set cnt=0, and stay in SHIFT.
  - Last byte without an input handshake: go to IDLE, clear cnt, clear the shift register.
- Stall: while out_ready=0, out_data, out_last and cnt stay stable. out_valid never drops once asserted, except on flush or reset.
- Flush:
  - State goes to IDLE, cnt to 0, shift register to 0 on the next edge.
  - in_ready=0 in the flush cycle; an input offered in that cycle is not taken.
  - A flush has priority over every handshake in the same cycle.
- cnt is log2(NBEATS) bits wide and never wraps. It is reloaded to 0 at the end of every block.

## Timing
- Reset values (while rst=0 and after release): state IDLE, cnt 0, shift register 0, out_valid 0, out_data 0, out_last 0, busy 0, in_ready 0.
- in_ready rises combinationally in the first cycle after rst releases.
- Latency: an input handshake at edge N puts the first byte on out_data after edge N; it is valid in cycle N+1.
- Throughput: with out_ready held at 1, a block takes NBEATS cycles. The next block follows with zero idle cycles when it is offered during the out_last cycle.
- If reset is asserted mid-block, outputs clear immediately (asynchronously) and the partial block is lost.

## Configuration
- BF_SER_PARITY_EN defined:
  - Adds output `out_par` (1 bit), the even parity of out_data. It is XOR-reduce, combinational, and valid whenever out_valid=1.
  - out_par is 0 in reset and in IDLE.
- BF_SER_PARITY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package bf_pkg holds:
  - BLOCK_W, BYTE_W and NBEATS constants.
  - The serializer state encoding (IDLE=0, SHIFT=1).
- Sub-module bf_shift_reg: a BLOCK_W-wide register with async active-low reset, a load port and a shift-by-BYTE_W enable. Load has priority over shift; clear has priority over both.
- The top level holds the FSM, cnt, the handshake logic and the optional parity.

## Test plan
- Single block: load in_data=64'h0123456789ABCDEF with out_ready=1 -> bytes 01,23,45,67,89,AB,CD,EF on cycles N+1..N+8; out_last only on EF; then IDLE, in_ready=1.
- Back-to-back: offer 64'h1111…11 then 64'h2222…22 with in_valid held -> 16 consecutive valid cycles with no gap; out_last on cycles 8 and 16.
- Backpressure: toggle out_ready 1,0,0,1 during block 64'hFEDCBA9876543210 -> out_data holds each byte while stalled; byte order unchanged; exactly 8 handshakes.
- Flush on byte 3 of 64'hA5A5…A5 with in_valid=1 in the same cycle -> next cycle out_valid=0, busy=0, new block not taken; it is taken in the following cycle.
- Async reset mid-block (rst=0 for 2 cycles at beat 5) -> out_valid, out_data and out_last go to 0 immediately; after release, in_ready=1 and the next block starts at its first byte.
- With BF_SER_PARITY_EN: block 64'h0103070F1F3F7FFF -> out_par sequence 1,0,1,0,1,0,1,0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared constants and serializer state encoding for the Blowfish block output stage.
package bf_pkg;
  localparam int BLOCK_W = 64;
  localparam int BYTE_W  = 8;
  localparam int NBEATS  = BLOCK_W / BYTE_W;
  localparam int CNT_W   = $clog2(NBEATS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;
endpackage

// File: rtl/bf_block_serializer_if.sv
// Block-in / byte-out handshake bundle for bf_block_serializer.
// Carries out_par only when BF_SER_PARITY_EN is defined.
interface bf_block_serializer_if;
  import bf_pkg::*;

  logic               flush;
  logic [BLOCK_W-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [BYTE_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
`ifdef BF_SER_PARITY_EN
  logic               out_par;
`endif

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
`ifdef BF_SER_PARITY_EN
    , input out_par
`endif
  );

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
`ifdef BF_SER_PARITY_EN
    , output out_par
`endif
  );
endinterface

// File: rtl/bf_shift_reg.sv
// BLOCK_W-wide shift register that shifts left by one byte with zero fill.
// Priority: clear over load over shift.
module bf_shift_reg
  import bf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic               shift,
  input  logic [BLOCK_W-1:0] load_data,
  output logic [BLOCK_W-1:0] q
);
  logic [BLOCK_W-1:0] sr_d, sr_q;

  always_comb begin
    sr_d = sr_q;
    if (clr)
      sr_d = '0;
    else if (load)
      sr_d = load_data;
    else if (shift)
      sr_d = {sr_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sr_q <= '0;
    else
      sr_q <= sr_d;
  end

  assign q = sr_q;
endmodule

// File: rtl/bf_block_serializer.sv
// Streams 64-bit cipher blocks out MSB byte first over a valid/ready byte interface.
// Optional even-parity output enabled by defining BF_SER_PARITY_EN.
module bf_block_serializer
  import bf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  bf_block_serializer_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

  ser_state_e         state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [BLOCK_W-1:0] sr_q;
  logic               out_fire, at_last, in_fire;
  logic               sr_clr, sr_load, sr_shift;

  assign at_last  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign out_fire = (state_q == ST_SHIFT) && bus.out_ready;
  // Reset gates in_ready combinationally so it rises in the first cycle after release.
  assign bus.in_ready = rst && !bus.flush &&
                        ((state_q == ST_IDLE) || (out_fire && at_last));
  assign in_fire  = bus.in_valid && bus.in_ready;

  assign sr_clr   = bus.flush || (out_fire && at_last && !in_fire);
  assign sr_load  = in_fire;
  assign sr_shift = out_fire && !at_last;

  bf_shift_reg u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .clr       (sr_clr),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (bus.in_data),
    .q         (sr_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (in_fire) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
    end else if (out_fire) begin
      if (at_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_data  = sr_q[BLOCK_W-1 -: BYTE_W];
  assign bus.out_valid = (state_q == ST_SHIFT);
  assign bus.out_last  = at_last;
  assign bus.busy      = (state_q == ST_SHIFT);

`ifdef BF_SER_PARITY_EN
  // Shift register is zero in IDLE and reset, so parity reads 0 there too.
  assign bus.out_par = ^sr_q[BLOCK_W-1 -: BYTE_W];
`endif
endmodule

// File: tb/tb_bf_block_serializer.sv
// Directed bench for bf_block_serializer; parity checks run when BF_SER_PARITY_EN is defined.
module tb_bf_block_serializer;
  import bf_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bf_block_serializer_if bus ();

  bf_block_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] blk, input int i);
    return blk[63-8*i -: 8];
  endfunction

  initial begin
    logic [63:0] blk;
    logic [63:0] blk2;
    logic [3:0]  pat;
    logic [7:0]  parseq;
    int          idx;
    int          hs;

    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Single block
    blk = 64'h0123456789ABCDEF;
    bus.in_data   = blk;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("single_valid", 64'(bus.out_valid), 64'd1);
      chk("single_data",  64'(bus.out_data),  64'(byte_of(blk, i)));
      chk("single_last",  64'(bus.out_last),  (i == 7) ? 64'd1 : 64'd0);
      tick();
    end
    chk("single_end_valid", 64'(bus.out_valid), 64'd0);
    chk("single_end_busy",  64'(bus.busy),      64'd0);
    chk("single_end_rdy",   64'(bus.in_ready),  64'd1);

    // Back-to-back blocks
    blk  = 64'h1111111111111111;
    blk2 = 64'h2222222222222222;
    bus.in_data  = blk;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = blk2;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) bus.in_valid = 1'b0;
      #1;
      chk("b2b_valid", 64'(bus.out_valid), 64'd1);
      chk("b2b_data",  64'(bus.out_data),  (c < 8) ? 64'h11 : 64'h22);
      chk("b2b_last",  64'(bus.out_last),  (c == 7 || c == 15) ? 64'd1 : 64'd0);
      if (c == 3) chk("b2b_busy_rdy", 64'(bus.in_ready), 64'd0);
      tick();
    end
    chk("b2b_end_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure with out_ready pattern 1,0,0,1
    blk = 64'hFEDCBA9876543210;
    pat = 4'b1001;
    bus.in_data  = blk;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    idx = 0;
    hs  = 0;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = pat[3 - (c % 4)];
      #1;
      if (!bus.out_valid) break;
      chk("bp_data", 64'(bus.out_data), 64'(byte_of(blk, idx)));
      chk("bp_last", 64'(bus.out_last), (idx == 7) ? 64'd1 : 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        hs++;
        idx++;
      end
      tick();
    end
    chk("bp_handshakes", 64'(hs), 64'd8);
    bus.out_ready = 1'b1;

    // Flush on byte 3 with a competing input offer
    blk  = 64'hA5A5A5A5A5A5A5A5;
    blk2 = 64'h5A5A5A5A5A5A5A5A;
    bus.in_data  = blk;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    bus.flush    = 1'b1;
    bus.in_data  = blk2;
    bus.in_valid = 1'b1;
    #1;
    chk("flush_rdy",  64'(bus.in_ready), 64'd0);
    chk("flush_data", 64'(bus.out_data), 64'hA5);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_busy",  64'(bus.busy),      64'd0);
    chk("flush_odata", 64'(bus.out_data),  64'd0);
    chk("flush_rdy2",  64'(bus.in_ready),  64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("flush_new_valid", 64'(bus.out_valid), 64'd1);
    chk("flush_new_data",  64'(bus.out_data),  64'h5A);
    chk("flush_new_last",  64'(bus.out_last),  64'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("flush_drain", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-block at beat 5
    blk = 64'h0123456789ABCDEF;
    bus.in_data  = blk;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("ar_beat5", 64'(bus.out_data), 64'hAB);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_data",  64'(bus.out_data),  64'd0);
    chk("ar_last",  64'(bus.out_last),  64'd0);
    chk("ar_rdy",   64'(bus.in_ready),  64'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("ar_rel_rdy",   64'(bus.in_ready),  64'd1);
    chk("ar_rel_valid", 64'(bus.out_valid), 64'd0);
    bus.in_data  = 64'hFEDCBA9876543210;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("ar_next_data",  64'(bus.out_data),  64'hFE);
    chk("ar_next_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 8; i++) tick();

`ifdef BF_SER_PARITY_EN
    chk("par_idle", 64'(bus.out_par), 64'd0);
    parseq = 8'b10101010;
    bus.in_data  = 64'h0103070F1F3F7FFF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("par_seq", 64'(bus.out_par), 64'(parseq[7-i]));
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
